// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the FSM encoding and the {pc, instr} bundle.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   localparam logic [31:0] BUBBLE_INSTR = 32'b0;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_INC   = 32'd4;

endpackage

// File: rtl/if_skid_reg.sv
// One-entry {pc, instr} holding register.
// Catches a completing fetch while the stage is frozen.
module if_skid_reg
   import if_fetch_unit_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   clear,
   input  fetch_t d,
   output fetch_t q,
   output logic   valid
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem request, bubble insertion,
// freeze handling with a skid entry, and branch redirect.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   state_t      state;
   fetch_t      out_q;
   logic        out_vld;
   fetch_t      skid_q;
   logic        skid_vld;
   logic        cpl;
   logic [31:0] next_addr;
   logic        skid_load;
   logic        skid_clear;

   assign cpl       = imem_req & imem_rvalid;
   assign next_addr = imem_addr + PC_INC;

   assign skid_load  = (state == RUN) & ~branch_taken & cpl & freeze;
   assign skid_clear = (state != BOOT) &
                       (branch_taken | ((state == STALL) & ~freeze));

   if_skid_reg u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     ('{pc: next_addr, instr: imem_rdata}),
      .q     (skid_q),
      .valid (skid_vld)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         out_q     <= '0;
         out_vld   <= 1'b0;
      end else begin
         unique case (state)
            BOOT: begin
               state    <= RUN;
               imem_req <= 1'b1;
            end
            RUN: begin
               if (branch_taken) begin
                  imem_addr <= branch_addr;
                  imem_req  <= 1'b1;
                  out_q     <= '{pc: 32'b0, instr: BUBBLE_INSTR};
                  out_vld   <= 1'b0;
               end else if (cpl && !freeze) begin
                  out_q     <= '{pc: next_addr, instr: imem_rdata};
                  out_vld   <= 1'b1;
                  imem_addr <= next_addr;
               end else if (cpl) begin
                  imem_addr <= next_addr;
                  imem_req  <= 1'b0;
                  state     <= STALL;
               end else if (!freeze) begin
                  out_q     <= '{pc: 32'b0, instr: BUBBLE_INSTR};
                  out_vld   <= 1'b0;
               end
            end
            STALL: begin
               if (branch_taken) begin
                  imem_addr <= branch_addr;
                  imem_req  <= 1'b1;
                  out_q     <= '{pc: 32'b0, instr: BUBBLE_INSTR};
                  out_vld   <= 1'b0;
                  state     <= RUN;
               end else if (!freeze) begin
                  out_q     <= skid_q;
                  out_vld   <= skid_vld;
                  imem_req  <= 1'b1;
                  state     <= RUN;
               end
            end
            default: begin
               state    <= BOOT;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign pc_out          = out_q.pc;
   assign instruction_out = out_q.instr;
   assign valid_out       = out_vld;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed stimulus pushes
// expected {pc, instr} words, a negedge monitor pops and compares.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        valid_out;
   logic        mem_ready;
   logic        mon_en = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_pc[$];
   logic [31:0] exp_ins[$];

   always #5 clk = ~clk;

   assign imem_rvalid = mem_ready;
   assign imem_rdata  = imem_addr;

   if_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] ins);
      exp_pc.push_back(pc);
      exp_ins.push_back(ins);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // IF/ID takes the presented word at the next edge when not frozen
   always @(negedge clk) begin
      if (mon_en && rst && valid_out && !freeze) begin
         n_vec++;
         if (exp_pc.size() == 0) begin
            n_err++;
            $display("FAIL consume: unexpected pc=%h ins=%h",
                     pc_out, instruction_out);
         end else begin
            logic [31:0] ep, ei;
            ep = exp_pc.pop_front();
            ei = exp_ins.pop_front();
            if (pc_out !== ep || instruction_out !== ei) begin
               n_err++;
               $display("FAIL consume: got pc=%h ins=%h want pc=%h ins=%h",
                        pc_out, instruction_out, ep, ei);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
      branch_addr = '0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_ins", instruction_out, 32'h0);
      chk("rst_vld", 32'(valid_out), 32'd0);
      rst = 1'b1;

      // T1/T2: boot, sequential, then 3 wait states at addr 8
      step();
      chk("boot_vld", 32'(valid_out), 32'd0);
      chk("boot_req", 32'(imem_req), 32'd1);
      chk("boot_addr", imem_addr, 32'h0);
      push(32'd4, 32'd0); push(32'd8, 32'd4);
      push(32'd12, 32'd8); push(32'd16, 32'd12);
      step(); step();
      chk("t1_addr", imem_addr, 32'd8);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_vld", 32'(valid_out), 32'd0);
         chk("t2_ins", instruction_out, 32'h0);
         chk("t2_addr", imem_addr, 32'd8);
      end
      mem_ready = 1'b1;
      step();
      chk("t2_pc", pc_out, 32'd12);
      chk("t2_word", instruction_out, 32'd8);
      step();

      // T3: freeze 4 cycles, skid catches word at 16
      freeze = 1'b1;
      push(32'd20, 32'd16); push(32'd24, 32'd20);
      step();
      chk("t3_req", 32'(imem_req), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold_pc", pc_out, 32'd16);
         chk("t3_hold_ins", instruction_out, 32'd12);
         chk("t3_hold_vld", 32'(valid_out), 32'd1);
         chk("t3_hold_req", 32'(imem_req), 32'd0);
      end
      freeze = 1'b0;
      step();
      chk("t3_rel_req", 32'(imem_req), 32'd1);
      chk("t3_rel_pc", pc_out, 32'd20);
      step(); step();

      // T4: branch while frozen with full skid
      freeze = 1'b1;
      step();
      chk("t4_stall_req", 32'(imem_req), 32'd0);
      branch_taken = 1'b1; branch_addr = 32'h100;
      step();
      chk("t4_vld", 32'(valid_out), 32'd0);
      chk("t4_pc", pc_out, 32'h0);
      chk("t4_ins", instruction_out, 32'h0);
      chk("t4_addr", imem_addr, 32'h100);
      chk("t4_req", 32'(imem_req), 32'd1);
      branch_taken = 1'b0; freeze = 1'b0;
      push(32'h104, 32'h100);
      step();

      // T5: branch on completing edge discards word at 0x104
      branch_taken = 1'b1; branch_addr = 32'h200;
      push(32'h204, 32'h200);
      step();
      chk("t5_vld", 32'(valid_out), 32'd0);
      chk("t5_addr", imem_addr, 32'h200);
      branch_taken = 1'b0;
      step(); step();

      // T6: reset in STALL, reset in wait state, PC wrap
      freeze = 1'b1;
      step();
      chk("t6_stall_req", 32'(imem_req), 32'd0);
      rst = 1'b0;
      #1;
      chk("t6a_pc", pc_out, 32'h0);
      chk("t6a_ins", instruction_out, 32'h0);
      chk("t6a_vld", 32'(valid_out), 32'd0);
      chk("t6a_req", 32'(imem_req), 32'd0);
      chk("t6a_addr", imem_addr, 32'h0);
      freeze = 1'b0;
      step(); rst = 1'b1;
      step();
      push(32'd4, 32'd0);
      step();
      mem_ready = 1'b0;
      step();
      chk("t6b_wait_addr", imem_addr, 32'd4);
      chk("t6b_wait_vld", 32'(valid_out), 32'd0);
      rst = 1'b0;
      #1;
      chk("t6b_addr", imem_addr, 32'h0);
      chk("t6b_req", 32'(imem_req), 32'd0);
      mem_ready = 1'b1;
      step(); rst = 1'b1;
      step();
      push(32'd4, 32'd0);
      step();
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      step();
      chk("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);
      branch_taken = 1'b0;
      push(32'h0, 32'hFFFF_FFFC); push(32'd4, 32'd0);
      step();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc", pc_out, 32'h0);
      step();
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("drain", 32'(exp_pc.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
